// File: rtl/or_gate_exerciser_pkg.sv
// Shared definitions for the OR-gate exerciser: FSM encoding and width helper.
// Purely declarative, with no logic and no latency.
// No flow control.
package or_gate_exerciser_pkg;

  // FSM state encoding, kept as plain constants for legacy tool flows
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // Bits needed to count 0..v-1, never less than one bit
  function automatic int clog2_min1(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/exerciser_hold_timer.sv
// Hold timer: counts cycles within one stimulus vector and flags the last one.
// last is combinational from the counter; the count advances one step per enabled cycle.
// Backpressure: none. clr takes priority over en.
module exerciser_hold_timer
  import or_gate_exerciser_pkg::*;
#(
  parameter int HOLD = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic last
);

  localparam int CW = clog2_min1(HOLD);
  localparam logic [CW-1:0] LAST_CNT = CW'(HOLD - 1);

  logic [CW-1:0] cnt;

  // Count up to HOLD-1, then wrap so the next vector starts from zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= last ? '0 : cnt + 1'b1;
    end
  end

  assign last = (cnt == LAST_CNT);

endmodule

// File: rtl/or_gate_exerciser.sv
// Sweeps every input vector of an N-input OR gate and checks the gate output against |stim.
// Sweep takes 2^N_IN*HOLD cycles from the accepting edge to done; dut_y is sampled on the last hold cycle.
// Backpressure: none. start is honoured only in IDLE or DONE and ignored while a sweep runs.
module or_gate_exerciser
  import or_gate_exerciser_pkg::*;
#(
  parameter int N_IN  = 3,
  parameter int HOLD  = 10,
  parameter int ERR_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             dut_y,
  output logic [N_IN-1:0]  stim,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic             fail_valid,
  output logic [N_IN-1:0]  fail_vec
);

  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  logic [1:0]       state;
  logic             hold_last;
  logic             accept;
  logic             sample;
  logic             mismatch;
  logic             at_end;
  logic [ERR_W-1:0] err_next;

  assign accept   = start && ((state == IDLE) || (state == DONE));
  assign sample   = (state == RUN) && hold_last;
  assign mismatch = sample && (dut_y != (|stim));
  assign at_end   = &stim;

  exerciser_hold_timer #(
    .HOLD(HOLD)
  ) u_hold_timer (
    .clk  (clk),
    .rst  (rst),
    .clr  (accept),
    .en   (state == RUN),
    .last (hold_last)
  );

  // Saturating increment of the mismatch count for the current sample
  always_comb begin
    err_next = err_count;
    if (mismatch && (err_count != ERR_MAX)) begin
      err_next = err_count + 1'b1;
    end
  end

  // Sweep FSM, vector counter and error log
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      stim       <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_count  <= '0;
      fail_valid <= 1'b0;
      fail_vec   <= '0;
    end else if (accept) begin
      state      <= RUN;
      stim       <= '0;
      busy       <= 1'b1;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_count  <= '0;
      fail_valid <= 1'b0;
      fail_vec   <= '0;
    end else if (sample) begin
      err_count <= err_next;
      if (mismatch && !fail_valid) begin
        fail_valid <= 1'b1;
        fail_vec   <= stim;
      end
      if (at_end) begin
        // Last vector stays on stim while results are presented
        state <= DONE;
        busy  <= 1'b0;
        done  <= 1'b1;
        pass  <= (err_next == '0);
      end else begin
        stim <= stim + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_or_gate_exerciser.sv
// Bench for or_gate_exerciser: two instances (HOLD=10/ERR_W=4 and HOLD=1/ERR_W=2) driven by gate models.
// Expected sweep results are queued at start and compared by monitors when done rises.
// Stim timing is checked every cycle against elapsed cycles since the accepting edge.
module tb_or_gate_exerciser;

  typedef struct {
    int err;
    int fvld;
    int fvec;
    int pass;
    int accept;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       start_a = 1'b0, start_b = 1'b0;
  logic       y_a, y_b;
  logic [2:0] stim_a, stim_b, fvec_a, fvec_b;
  logic       busy_a, busy_b, done_a, done_b, pass_a, pass_b, fvld_a, fvld_b;
  logic [3:0] err_a;
  logic [1:0] err_b;

  int         mode_a = 0, mode_b = 0;
  logic [7:0] mask_a = 8'h00, mask_b = 8'h00;

  int cyc = 0;
  int checks = 0;
  int passes = 0;
  int acc_a = -1, acc_b = -1;
  logic done_prev_a = 1'b0, done_prev_b = 1'b0;
  res_t q_a[$];
  res_t q_b[$];

  // Gate under test: 0 = OR, 1 = AND, 2 = stuck at 0, 3 = OR with per-vector flips from mask
  function automatic logic gate(input int mode, input logic [7:0] mask, input logic [2:0] v);
    case (mode)
      0:       return |v;
      1:       return &v;
      2:       return 1'b0;
      default: return (|v) ^ mask[v];
    endcase
  endfunction

  // Reference: OR of a 3-bit vector is 1 unless the vector is zero
  function automatic res_t model(input int mode, input logic [7:0] mask, input int errmax);
    res_t r;
    int n;
    n = 0;
    r.fvld = 0;
    r.fvec = 0;
    for (int v = 0; v < 8; v++) begin
      logic [2:0] vv;
      vv = 3'(v);
      if (int'(gate(mode, mask, vv)) != ((v != 0) ? 1 : 0)) begin
        if (n == 0) begin
          r.fvld = 1;
          r.fvec = v;
        end
        n++;
      end
    end
    r.err    = (n > errmax) ? errmax : n;
    r.pass   = (n == 0) ? 1 : 0;
    r.accept = 0;
    return r;
  endfunction

  assign y_a = gate(mode_a, mask_a, stim_a);
  assign y_b = gate(mode_b, mask_b, stim_b);

  or_gate_exerciser #(.N_IN(3), .HOLD(10), .ERR_W(4)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .dut_y(y_a), .stim(stim_a), .busy(busy_a),
    .done(done_a), .pass(pass_a), .err_count(err_a), .fail_valid(fvld_a), .fail_vec(fvec_a)
  );

  or_gate_exerciser #(.N_IN(3), .HOLD(1), .ERR_W(2)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .dut_y(y_b), .stim(stim_b), .busy(busy_b),
    .done(done_b), .pass(pass_b), .err_count(err_b), .fail_valid(fvld_b), .fail_vec(fvec_b)
  );

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Monitor A: stim timing every cycle, full result when done rises
  always begin
    @(negedge clk);
    #1;
    if (acc_a >= 0 && busy_a) chk("stim_a", int'(stim_a), (cyc - acc_a) / 10);
    if (done_a && !done_prev_a) begin
      if (q_a.size() == 0) begin
        checks++;
        $display("FAIL done_a_unexpected: got done=1 expected no pending sweep");
      end else begin
        res_t r;
        r = q_a.pop_front();
        chk("latency_a", cyc - r.accept, 80);
        chk("err_a", int'(err_a), r.err);
        chk("fvld_a", int'(fvld_a), r.fvld);
        chk("fvec_a", int'(fvec_a), r.fvec);
        chk("pass_a", int'(pass_a), r.pass);
        chk("final_stim_a", int'(stim_a), 7);
        chk("busy_off_a", int'(busy_a), 0);
      end
      acc_a = -1;
    end
    done_prev_a = done_a;
  end

  // Monitor B: same checks for the HOLD=1 instance
  always begin
    @(negedge clk);
    #1;
    if (acc_b >= 0 && busy_b) chk("stim_b", int'(stim_b), cyc - acc_b);
    if (done_b && !done_prev_b) begin
      if (q_b.size() == 0) begin
        checks++;
        $display("FAIL done_b_unexpected: got done=1 expected no pending sweep");
      end else begin
        res_t r;
        r = q_b.pop_front();
        chk("latency_b", cyc - r.accept, 8);
        chk("err_b", int'(err_b), r.err);
        chk("fvld_b", int'(fvld_b), r.fvld);
        chk("fvec_b", int'(fvec_b), r.fvec);
        chk("pass_b", int'(pass_b), r.pass);
      end
      acc_b = -1;
    end
    done_prev_b = done_b;
  end

  task automatic issue_a(input int mode, input logic [7:0] mask);
    res_t r;
    @(negedge clk);
    mode_a  = mode;
    mask_a  = mask;
    start_a = 1'b1;
    @(negedge clk);
    start_a  = 1'b0;
    r        = model(mode, mask, 15);
    r.accept = cyc;
    acc_a    = cyc;
    q_a.push_back(r);
  endtask

  task automatic issue_b(input int mode, input logic [7:0] mask);
    res_t r;
    @(negedge clk);
    mode_b  = mode;
    mask_b  = mask;
    start_b = 1'b1;
    @(negedge clk);
    start_b  = 1'b0;
    r        = model(mode, mask, 3);
    r.accept = cyc;
    acc_b    = cyc;
    q_b.push_back(r);
  endtask

  task automatic wait_done_a();
    int n;
    n = 0;
    while (!done_a && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!done_a) begin
      checks++;
      $display("FAIL done_a_timeout: got done=0 expected done within 200 cycles");
      q_a.delete();
      acc_a = -1;
    end
    @(negedge clk);
  endtask

  task automatic wait_done_b();
    int n;
    n = 0;
    while (!done_b && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!done_b) begin
      checks++;
      $display("FAIL done_b_timeout: got done=0 expected done within 50 cycles");
      q_b.delete();
      acc_b = -1;
    end
    @(negedge clk);
  endtask

  task automatic chk_cleared_a(input string tag);
    chk({tag, "_done"}, int'(done_a), 0);
    chk({tag, "_pass"}, int'(pass_a), 0);
    chk({tag, "_err"}, int'(err_a), 0);
    chk({tag, "_fvld"}, int'(fvld_a), 0);
    chk({tag, "_busy"}, int'(busy_a), 1);
  endtask

  task automatic chk_reset_a(input string tag);
    chk({tag, "_stim"}, int'(stim_a), 0);
    chk({tag, "_busy"}, int'(busy_a), 0);
    chk({tag, "_done"}, int'(done_a), 0);
    chk({tag, "_pass"}, int'(pass_a), 0);
    chk({tag, "_err"}, int'(err_a), 0);
    chk({tag, "_fvld"}, int'(fvld_a), 0);
    chk({tag, "_fvec"}, int'(fvec_a), 0);
  endtask

  initial begin
    #1;
    chk_reset_a("rst_a");
    chk("rst_b_busy", int'(busy_b), 0);
    chk("rst_b_done", int'(done_b), 0);
    chk("rst_b_err", int'(err_b), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Correct OR gate with extra start pulses during the sweep
    issue_a(0, 8'h00);
    repeat (4) @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (34) @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    wait_done_a();

    // AND gate started from DONE: results clear on the accepting edge
    issue_a(1, 8'h00);
    chk_cleared_a("restart_after_pass");
    wait_done_a();

    // Correct OR gate again after a failing sweep
    issue_a(0, 8'h00);
    chk_cleared_a("restart_after_fail");
    wait_done_a();

    // Stuck-at-0 output
    issue_a(2, 8'h00);
    wait_done_a();

    // Randomized faulty gates
    for (int i = 0; i < 4; i++) begin
      issue_a(3, 8'($urandom_range(0, 255)));
      wait_done_a();
    end

    // Asynchronous reset mid-sweep while vector 4 is applied
    issue_a(0, 8'h00);
    repeat (44) @(negedge clk);
    chk("stim_before_rst", int'(stim_a), 4);
    #2;
    rst = 1'b1;
    q_a.delete();
    acc_a = -1;
    #1;
    chk_reset_a("async_rst_a");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    issue_a(0, 8'h00);
    wait_done_a();

    // HOLD=1 instance: correct gate, stuck-at-0 saturation, then random faults
    issue_b(0, 8'h00);
    wait_done_b();
    issue_b(2, 8'h00);
    wait_done_b();
    issue_b(1, 8'h00);
    wait_done_b();
    for (int i = 0; i < 6; i++) begin
      issue_b(3, 8'($urandom_range(0, 255)));
      wait_done_b();
    end

    repeat (3) @(negedge clk);
    chk("q_a_drained", q_a.size(), 0);
    chk("q_b_drained", q_b.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected completion before 500000");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/or_gate_exerciser.md
Name: or_gate_exerciser

Overview:
- Self-checking stimulus/response driver for an N-input OR gate: drives the gate's inputs and checks its single output.
- Walks all 2^N_IN input combinations in ascending binary order and holds each for HOLD cycles.
- Samples the gate output and compares it against the reduction-OR of the applied vector.
- Accumulates a mismatch count and records the first failing vector; sits beside any combinational gate under test in place of a hand-written stimulus block.

Parameters:
- N_IN, 3, number of gate inputs (1..8).
- HOLD, 10, clock cycles each vector is held (>=1).
- ERR_W, 4, width of the mismatch counter.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to begin a sweep; honoured only in IDLE or DONE.
- dut_y  in  1  output of the gate under test.
- stim  out  N_IN  vector driven to the gate inputs (bit 0 = first input).
- busy  out  1  high while a sweep is in progress.
- done  out  1  high from sweep completion until the next accepted start.
- pass  out  1  valid while done=1; high iff err_count==0.
- err_count  out  ERR_W  number of mismatching vectors, saturating.
- fail_valid  out  1  a mismatch has been recorded in this sweep.
- fail_vec  out  N_IN  first vector that mismatched; 0 when fail_valid=0.

Behaviour:
- Reset (asynchronous, any state): state=IDLE; stim=0, busy=0, done=0, pass=0, err_count=0, fail_valid=0, fail_vec=0, hold_cnt=0.
- FSM states: IDLE, RUN, DONE.
- IDLE/DONE to RUN: taken on the edge where start=1.
  - Same edge: stim<=0, hold_cnt<=0, err_count<=0, fail_valid<=0, fail_vec<=0, done<=0, pass<=0, busy<=1.
- RUN, each cycle:
  - If hold_cnt != HOLD-1: hold_cnt increments.
  - If hold_cnt == HOLD-1 (sample cycle): compare dut_y against expected = |stim.
  - On mismatch: err_count increments, saturating at 2^ERR_W-1. If fail_valid=0, fail_vec<=stim and fail_valid<=1.
  - After a sample, if stim == all-ones: go to DONE, with busy<=0, done<=1, pass<=(final err_count==0). The final count includes this last comparison.
  - After a sample otherwise: stim<=stim+1 and hold_cnt<=0.
- Timing: done rises on the edge 2^N_IN*HOLD cycles after the edge that accepted start. With N_IN=3, HOLD=10, that is 80 cycles.
- stim stays stable for exactly HOLD cycles per vector. The last vector (all-ones) stays on stim in DONE until the next start or reset.
- start while in RUN: ignored, with no restart and no effect on counters.
- start in DONE: begins a new sweep and clears all results, as from IDLE.
- HOLD=1: every RUN cycle is a sample cycle, and stim advances each cycle.
- dut_y is sampled only on sample cycles; its value on other cycles is don't-care. This allows gate settling time.
- Reset during RUN: immediately returns to IDLE with all outputs at reset values. The partial results are discarded.
- Widths:
  - hold_cnt is clog2(HOLD) bits, minimum 1.
  - stim increment never wraps, because the sweep ends at all-ones.

Decomposition:
- Shared package or `include:
  - state encoding constants: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - clog2 helper for the hold_cnt width.
- One sub-module, exerciser_hold_timer: parameter HOLD; inputs clk, rst, clr, en; output last.
  - last is high when the count equals HOLD-1.
  - clr has priority over en.
- Everything else (FSM, vector counter, compare, error log) lives in or_gate_exerciser.

Test Plan:
- Correct 3-input OR as the gate, HOLD=10, one start pulse:
  - stim steps 0..7, 10 cycles each.
  - done=1 on the 80th edge after start; pass=1, err_count=0, fail_valid=0.
- Gate replaced by 3-input AND:
  - Mismatches on vectors 1-6.
  - Result: err_count=6, fail_vec=3'b001, fail_valid=1, pass=0.
- dut_y stuck at 0, ERR_W=2:
  - 7 mismatches, so err_count saturates at 3.
  - fail_vec=3'b001, pass=0.
- Extra start pulses during RUN (at cycles 5 and 40):
  - Sweep is not restarted; done still rises on the 80th edge.
  - Then a start in DONE clears done, pass and err_count on the next edge and reruns.
- rst pulsed mid-sweep while stim=3'b100:
  - All outputs return to 0 immediately, without waiting for a clock edge.
  - A following start gives a full clean sweep with pass=1 (correct OR gate).
- HOLD=1 with a correct OR gate: stim increments every cycle; done rises on the 8th edge after start with pass=1.
